// File: rtl/mnist_pkg.sv
// Shared widths and limits for the MNIST accelerator datapath.
// Used by the requantization stage and the output-layer path.
package mnist_pkg;
  localparam int ACC_W     = 20;
  localparam int BIAS_W    = 16;
  localparam int SUM_W     = 21;
  localparam int OUT_W     = 8;
  localparam int OUT_MAX   = 127;
  localparam int OUT_MIN   = -128;
  localparam int SHIFT_W   = 5;
  localparam int SHIFT_MAX = 20;
  localparam int N_NEURONS = 32;
  localparam int SAT_W     = 16;
endpackage

// File: rtl/requant_core.sv
// Combinational requantizer: round-half-up arithmetic shift, optional ReLU,
// saturation to a signed OUT_W result with a flag when the clamp bites.
module requant_core
  import mnist_pkg::*;
#(
  parameter int SUM_W = mnist_pkg::SUM_W,
  parameter int OUT_W = mnist_pkg::OUT_W
) (
  input  logic signed [SUM_W-1:0]   sum_i,
  input  logic        [SHIFT_W-1:0] shift_i,
  input  logic                      relu_i,
  output logic        [OUT_W-1:0]   data_o,
  output logic                      sat_o
);

  localparam int T_W = SUM_W + 1;
  localparam logic signed [T_W-1:0] MAX_T = T_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [T_W-1:0] MIN_T = ~MAX_T;

  logic        [SHIFT_W-1:0] sh;
  logic signed [T_W-1:0]     rnd;
  logic signed [T_W-1:0]     t;
  logic signed [T_W-1:0]     r;

  always_comb begin
    sh = (shift_i > SHIFT_W'(SHIFT_MAX)) ? SHIFT_W'(SHIFT_MAX) : shift_i;
    rnd = '0;
    if (sh != '0) rnd = T_W'(1) << (sh - 1'b1);
    t = {sum_i[SUM_W-1], sum_i} + rnd;
    r = t >>> sh;
    // ReLU zeroing is not a saturation event, so it happens before the clamp.
    if (relu_i && r[T_W-1]) r = '0;
    sat_o  = 1'b0;
    data_o = r[OUT_W-1:0];
    if (r > MAX_T) begin
      data_o = MAX_T[OUT_W-1:0];
      sat_o  = 1'b1;
    end else if (r < MIN_T) begin
      data_o = MIN_T[OUT_W-1:0];
      sat_o  = 1'b1;
    end
  end

endmodule

// File: rtl/acc_requant.sv
// Two-stage valid/ready requantization pipeline: bias add in stage 1,
// shift/ReLU/saturate in stage 2, with neuron index tagging and sat stats.
module acc_requant
  import mnist_pkg::*;
#(
  parameter int ACC_W     = mnist_pkg::ACC_W,
  parameter int BIAS_W    = mnist_pkg::BIAS_W,
  parameter int OUT_W     = mnist_pkg::OUT_W,
  parameter int N_NEURONS = mnist_pkg::N_NEURONS,
  parameter int IDX_W     = $clog2(N_NEURONS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_stats,
  input  logic [SHIFT_W-1:0]  cfg_shift,
  input  logic                cfg_relu,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ACC_W-1:0]    in_acc,
  input  logic [BIAS_W-1:0]   in_bias,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic [IDX_W-1:0]    out_idx,
  output logic                out_last,
  output logic [SAT_W-1:0]    sat_count
);

  localparam int ACC_SUM_W = ((ACC_W > BIAS_W) ? ACC_W : BIAS_W) + 1;

  logic signed [ACC_SUM_W-1:0] acc_ext, bias_ext;
  logic                        s1_valid_q, s1_valid_d;
  logic signed [ACC_SUM_W-1:0] s1_sum_q, s1_sum_d;
  logic [SHIFT_W-1:0]          s1_shift_q, s1_shift_d;
  logic                        s1_relu_q, s1_relu_d;
  logic                        s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0]            s2_data_q, s2_data_d;
  logic                        s2_sat_q, s2_sat_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [SAT_W-1:0]            sat_cnt_q, sat_cnt_d;
  logic                        s2_adv, accept, out_hs;
  logic [OUT_W-1:0]            core_data;
  logic                        core_sat;

  assign acc_ext  = {{(ACC_SUM_W-ACC_W){in_acc[ACC_W-1]}}, in_acc};
  assign bias_ext = {{(ACC_SUM_W-BIAS_W){in_bias[BIAS_W-1]}}, in_bias};

  requant_core #(
    .SUM_W (ACC_SUM_W),
    .OUT_W (OUT_W)
  ) u_core (
    .sum_i   (s1_sum_q),
    .shift_i (s1_shift_q),
    .relu_i  (s1_relu_q),
    .data_o  (core_data),
    .sat_o   (core_sat)
  );

  // Handshake: a beat moves when its producer is valid and its consumer is
  // ready; a stage is ready when empty or when its content leaves this cycle.
  always_comb begin
    s2_adv   = !s2_valid_q || out_ready;
    in_ready = !s1_valid_q || s2_adv;
    accept   = in_valid && in_ready;
    out_hs   = s2_valid_q && out_ready;

    s1_valid_d = in_ready ? in_valid : s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s1_shift_d = s1_shift_q;
    s1_relu_d  = s1_relu_q;
    if (accept) begin
      s1_sum_d   = acc_ext + bias_ext;
      s1_shift_d = cfg_shift;
      s1_relu_d  = cfg_relu;
    end

    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_sat_d   = s2_sat_q;
    if (s2_adv && s1_valid_q) begin
      s2_data_d = core_data;
      s2_sat_d  = core_sat;
    end

    idx_d     = idx_q;
    sat_cnt_d = sat_cnt_q;
    if (clr_stats) begin
      idx_d     = '0;
      sat_cnt_d = '0;
    end else if (out_hs) begin
      idx_d = (idx_q == IDX_W'(N_NEURONS - 1)) ? '0 : idx_q + 1'b1;
      if (s2_sat_q && (sat_cnt_q != '1)) sat_cnt_d = sat_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s1_shift_q <= '0;
      s1_relu_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_sat_q   <= 1'b0;
      idx_q      <= '0;
      sat_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sum_q   <= s1_sum_d;
      s1_shift_q <= s1_shift_d;
      s1_relu_q  <= s1_relu_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_sat_q   <= s2_sat_d;
      idx_q      <= idx_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_idx   = idx_q;
  assign out_last  = (idx_q == IDX_W'(N_NEURONS - 1)) && s2_valid_q;
  assign sat_count = sat_cnt_q;

endmodule

// File: tb/tb_acc_requant.sv
// Self-checking bench for acc_requant: scoreboard of expected beats,
// backpressure, index wrap, stats clear and asynchronous reset.
module tb_acc_requant;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr_stats = 1'b0;
  logic [4:0]  cfg_shift = '0;
  logic        cfg_relu = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [19:0] in_acc = '0;
  logic [15:0] in_bias = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_data;
  logic [4:0]  out_idx;
  logic        out_last;
  logic [15:0] sat_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int hs_cyc = 0;
  int idx_m = 0;
  int sat_m = 0;
  logic [8:0] exp_q[$];

  acc_requant dut (
    .clk       (clk),
    .rst       (rst),
    .clr_stats (clr_stats),
    .cfg_shift (cfg_shift),
    .cfg_relu  (cfg_relu),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_acc    (in_acc),
    .in_bias   (in_bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .sat_count (sat_count)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference model: returns {sat, data}
  function automatic logic [8:0] model(input int acc, input int bias, input int shift, input bit relu);
    longint s, r;
    int sh;
    bit sat;
    logic [7:0] d;
    sh = (shift > 20) ? 20 : shift;
    s = longint'(acc) + longint'(bias);
    if (sh > 0) s = s + (longint'(1) << (sh - 1));
    r = s >>> sh;
    if (relu && r < 0) r = 0;
    sat = 1'b0;
    if (r > 127) begin r = 127; sat = 1'b1; end
    else if (r < -128) begin r = -128; sat = 1'b1; end
    d = r[7:0];
    return {sat, d};
  endfunction

  // driver
  task automatic send_beat(input int acc, input int bias, input int shift, input bit relu);
    int n;
    logic [19:0] a;
    logic [15:0] b;
    a = acc[19:0];
    b = bias[15:0];
    in_valid  = 1'b1;
    in_acc    = a;
    in_bias   = b;
    cfg_shift = shift[4:0];
    cfg_relu  = relu;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(acc, bias, shift, relu));
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        break;
      end
      n++;
      if (n > 200) begin
        check("accept_timeout", 32'(n), 0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 0);
    @(posedge clk);
    #1;
  endtask

  // scoreboard / output monitor
  always @(negedge clk) begin
    logic [8:0] e;
    logic hs;
    e = '0;
    hs = 1'b0;
    if (!rst) begin
      exp_q.delete();
      idx_m = 0;
      sat_m = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_unexpected", 0, 1);
        end else begin
          e = exp_q.pop_front();
          hs = 1'b1;
          hs_cyc = cyc;
          check("out_data", 32'(out_data), 32'(e[7:0]));
          check("out_idx", 32'(out_idx), 32'(idx_m));
          check("out_last", 32'(out_last), 32'(idx_m == 31));
          check("sat_count", 32'(sat_count), 32'(sat_m));
        end
      end
      if (clr_stats) begin
        idx_m = 0;
        sat_m = 0;
      end else if (hs) begin
        idx_m = (idx_m == 31) ? 0 : idx_m + 1;
        if (e[8] && sat_m != 16'hFFFF) sat_m++;
      end
    end
  end

  initial begin
    logic [7:0] held_d;
    logic [4:0] held_i;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_out_idx", 32'(out_idx), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_sat_count", 32'(sat_count), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 1);

    // basic rounding, latency
    send_beat(1000, 0, 4, 0);
    drain();
    check("latency", 32'(hs_cyc - acc_cyc), 2);
    send_beat(-1000, 0, 4, 0);
    send_beat(-1000, 0, 4, 1);
    drain();
    check("sat_none", 32'(sat_count), 0);

    // saturation both directions
    send_beat(524287, 32767, 0, 0);
    send_beat(-524288, -32768, 0, 0);
    drain();
    check("sat_two", 32'(sat_count), 2);

    // backpressure mid-stream
    out_ready = 1'b1;
    fork
      begin
        for (int v = 1; v <= 8; v++) send_beat(v, 0, 0, 0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        held_d = out_data;
        held_i = out_idx;
        repeat (4) @(negedge clk);
        check("stall_in_ready", 32'(in_ready), 0);
        check("stall_out_valid", 32'(out_valid), 1);
        check("stall_hold_data", 32'(out_data), 32'(held_d));
        check("stall_hold_idx", 32'(out_idx), 32'(held_i));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // idle clear, then 33 beats for index wrap
    @(posedge clk);
    #1;
    clr_stats = 1'b1;
    @(posedge clk);
    #1;
    clr_stats = 1'b0;
    check("clr_idx", 32'(out_idx), 0);
    check("clr_sat", 32'(sat_count), 0);
    for (int k = 0; k < 33; k++)
      send_beat(int'($urandom_range(0, 1048575)) - 524288, int'($urandom_range(0, 65535)) - 32768,
                int'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    drain();
    check("wrap_idx", 32'(out_idx), 1);

    // clear while streaming
    fork
      begin
        for (int k = 0; k < 12; k++)
          send_beat(int'($urandom_range(0, 1048575)) - 524288, int'($urandom_range(0, 65535)) - 32768,
                    int'($urandom_range(0, 6)), 1'b0);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        clr_stats = 1'b1;
        @(posedge clk);
        #1;
        clr_stats = 1'b0;
      end
    join
    drain();
    check("clr_stream_idx", 32'(out_idx), 32'(idx_m));
    check("clr_stream_sat", 32'(sat_count), 32'(sat_m));

    // asynchronous reset while stalled
    send_beat(524287, 0, 0, 0);
    drain();
    out_ready = 1'b0;
    send_beat(5, 0, 0, 0);
    send_beat(6, 0, 0, 0);
    @(posedge clk);
    #1;
    check("pre_rst_valid", 32'(out_valid), 1);
    rst = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_out_idx", 32'(out_idx), 0);
    check("arst_sat_count", 32'(sat_count), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    send_beat(300, 20, 2, 0);
    drain();
    check("post_rst_latency", 32'(hs_cyc - acc_cyc), 2);
    check("post_rst_idx", 32'(out_idx), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
